// File: rtl/ram_transaction_sequencer.sv
// ram_transaction_sequencer: runs N-beat four-phase MFA/MFC bursts between the control unit and the RAM.
// Define MFC_TIMEOUT_EN to build the MFC timeout abort; by default ASSERT waits for MFC indefinitely.
module ram_transaction_sequencer #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned BEAT_W  = 3,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [BEAT_W-1:0] req_beats,
  output logic              ready,
  output logic              beat_strobe,
  output logic [BEAT_W-1:0] beat_idx,
  output logic              done,
  output logic              error,
  output logic              ramMFA,
  output logic              ramRW,
  output logic [ADDR_W-1:0] ramAddress,
  output logic [1:0]        ramDataSize,
  input  logic              ramMFC
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_RELEASE = 2'd2,
    S_FIN     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic              beat_strobe_q, beat_strobe_d;
  logic [BEAT_W-1:0] beat_idx_q, beat_idx_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              mfa_q, mfa_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic              fault_q, fault_d;

`ifdef MFC_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              abort_q, abort_d;
`endif

  logic              illegal_c;
  logic              more_beats_c;
  logic [2:0]        step_c;

  // Request legality: reserved size or natural-alignment violation.
  always_comb begin
    illegal_c = 1'b0;
    case (req_size)
      2'b00:   illegal_c = 1'b0;
      2'b01:   illegal_c = req_addr[0];
      2'b10:   illegal_c = (req_addr[1:0] != 2'b00);
      default: illegal_c = 1'b1;
    endcase
  end

  // Address increment per beat follows the transfer size.
  always_comb begin
    case (size_q)
      2'b01:   step_c = 3'd2;
      2'b10:   step_c = 3'd4;
      default: step_c = 3'd1;
    endcase
  end

`ifdef MFC_TIMEOUT_EN
  assign more_beats_c = (beat_idx_q != (beats_q - BEAT_W'(1))) && !abort_q;
`else
  assign more_beats_c = (beat_idx_q != (beats_q - BEAT_W'(1)));
`endif

  always_comb begin
    state_d       = state_q;
    ready_d       = 1'b0;
    beat_strobe_d = 1'b0;
    done_d        = 1'b0;
    error_d       = 1'b0;
    beat_idx_d    = beat_idx_q;
    mfa_d         = mfa_q;
    rw_d          = rw_q;
    addr_d        = addr_q;
    size_d        = size_q;
    beats_d       = beats_q;
    fault_d       = fault_q;
`ifdef MFC_TIMEOUT_EN
    tmo_d         = tmo_q;
    abort_d       = abort_q;
`endif

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (ready_q && req) begin
          ready_d    = 1'b0;
          rw_d       = req_rw;
          addr_d     = req_addr;
          size_d     = req_size;
          beats_d    = (req_beats == '0) ? BEAT_W'(1) : req_beats;
          beat_idx_d = '0;
          fault_d    = illegal_c;
`ifdef MFC_TIMEOUT_EN
          tmo_d      = '0;
          abort_d    = 1'b0;
`endif
          if (illegal_c) begin
            state_d = S_FIN;
          end else begin
            state_d = S_ASSERT;
            mfa_d   = 1'b1;
          end
        end
      end

      S_ASSERT: begin
        if (ramMFC) begin
          beat_strobe_d = 1'b1;
          mfa_d         = 1'b0;
          state_d       = S_RELEASE;
        end
`ifdef MFC_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          mfa_d   = 1'b0;
          abort_d = 1'b1;
          state_d = S_RELEASE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end

      // Four-phase: the next beat may only start once MFC has returned low.
      S_RELEASE: begin
        if (!ramMFC) begin
`ifdef MFC_TIMEOUT_EN
          fault_d = fault_q | abort_q;
          tmo_d   = '0;
`endif
          if (more_beats_c) begin
            beat_idx_d = beat_idx_q + BEAT_W'(1);
            addr_d     = addr_q + ADDR_W'(step_c);
            mfa_d      = 1'b1;
            state_d    = S_ASSERT;
          end else begin
            state_d = S_FIN;
          end
        end
      end

      S_FIN: begin
        done_d  = 1'b1;
        error_d = fault_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ready_q       <= 1'b1;
      beat_strobe_q <= 1'b0;
      beat_idx_q    <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      mfa_q         <= 1'b0;
      rw_q          <= 1'b1;
      addr_q        <= '0;
      size_q        <= 2'b00;
      beats_q       <= BEAT_W'(1);
      fault_q       <= 1'b0;
`ifdef MFC_TIMEOUT_EN
      tmo_q         <= '0;
      abort_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      beat_strobe_q <= beat_strobe_d;
      beat_idx_q    <= beat_idx_d;
      done_q        <= done_d;
      error_q       <= error_d;
      mfa_q         <= mfa_d;
      rw_q          <= rw_d;
      addr_q        <= addr_d;
      size_q        <= size_d;
      beats_q       <= beats_d;
      fault_q       <= fault_d;
`ifdef MFC_TIMEOUT_EN
      tmo_q         <= tmo_d;
      abort_q       <= abort_d;
`endif
    end
  end

  assign ready       = ready_q;
  assign beat_strobe = beat_strobe_q;
  assign beat_idx    = beat_idx_q;
  assign done        = done_q;
  assign error       = error_q;
  assign ramMFA      = mfa_q;
  assign ramRW       = rw_q;
  assign ramAddress  = addr_q;
  assign ramDataSize = size_q;

endmodule

// File: tb/tb_ram_transaction_sequencer.sv
// Directed bench for ram_transaction_sequencer: bursts, wrap, illegal requests, reset, timeout, stuck MFC.
// Expectations for the MFC timeout scenario follow the MFC_TIMEOUT_EN macro.
module tb_ram_transaction_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic       req_rw;
  logic [8:0] req_addr;
  logic [1:0] req_size;
  logic [2:0] req_beats;
  logic       ready;
  logic       beat_strobe;
  logic [2:0] beat_idx;
  logic       done;
  logic       error;
  logic       ramMFA;
  logic       ramRW;
  logic [8:0] ramAddress;
  logic [1:0] ramDataSize;
  logic       ramMFC;

  int total = 0;
  int bad   = 0;

  // RAM responder and observation log, all advanced by cycle()
  bit   auto_mfc;
  int   mfc_delay;
  int   wait_cnt;
  int   mfa_hi, strobes, dones, errs;
  logic [8:0] addr_log [8];
  logic [2:0] idx_log  [8];

  ram_transaction_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_rw      (req_rw),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_beats   (req_beats),
    .ready       (ready),
    .beat_strobe (beat_strobe),
    .beat_idx    (beat_idx),
    .done        (done),
    .error       (error),
    .ramMFA      (ramMFA),
    .ramRW       (ramRW),
    .ramAddress  (ramAddress),
    .ramDataSize (ramDataSize),
    .ramMFC      (ramMFC)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    if (ramMFA) mfa_hi++;
    if (done) dones++;
    if (error) errs++;
    if (beat_strobe) begin
      if (strobes < 8) begin
        addr_log[strobes] = ramAddress;
        idx_log[strobes]  = beat_idx;
      end
      strobes++;
    end
    if (auto_mfc) begin
      if (ramMFA && !ramMFC) begin
        if (wait_cnt >= mfc_delay) ramMFC = 1'b1;
        else wait_cnt++;
      end else if (!ramMFA && ramMFC) begin
        ramMFC = 1'b0;
      end
      if (!ramMFA) wait_cnt = 0;
    end
  endtask

  task automatic clear_obs();
    mfa_hi = 0; strobes = 0; dones = 0; errs = 0; wait_cnt = 0;
  endtask

  task automatic start(input logic rw, input logic [8:0] a, input logic [1:0] sz, input logic [2:0] b);
    req = 1'b1; req_rw = rw; req_addr = a; req_size = sz; req_beats = b;
    cycle();
    req = 1'b0;
  endtask

  task automatic run_to_done(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles && dones == 0; i++) cycle();
    total++;
    if (dones == 0) begin
      bad++;
      $display("FAIL %s_done_timeout: got no done within %0d cycles, want done", name, max_cycles);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; req_rw = 1'b0; req_addr = '0; req_size = '0; req_beats = '0;
    ramMFC = 1'b0; auto_mfc = 1'b0; mfc_delay = 0;
    clear_obs();
    @(negedge clk);
    cycle();
    cycle();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready); end
    total++; if (ramMFA !== 1'b0) begin bad++; $display("FAIL reset_mfa: got %b want 0", ramMFA); end
    total++; if (ramRW !== 1'b1) begin bad++; $display("FAIL reset_rw: got %b want 1", ramRW); end
    total++; if (ramAddress !== 9'h000) begin bad++; $display("FAIL reset_addr: got %h want 000", ramAddress); end
    total++; if ({ramDataSize, beat_idx} !== 5'b0) begin bad++; $display("FAIL reset_size_idx: got %b want 00000", {ramDataSize, beat_idx}); end
    total++; if ({beat_strobe, done, error} !== 3'b000) begin bad++; $display("FAIL reset_pulses: got %b want 000", {beat_strobe, done, error}); end
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_word_read();
    auto_mfc = 1'b1; mfc_delay = 2; clear_obs();
    start(1'b1, 9'h010, 2'b10, 3'd1);
    total++; if (ramMFA !== 1'b1) begin bad++; $display("FAIL word_mfa_latency: got %b want 1", ramMFA); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL word_busy_ready: got %b want 0", ready); end
    run_to_done("word", 40);
    total++; if (mfa_hi !== 3) begin bad++; $display("FAIL word_mfa_cycles: got %0d want 3", mfa_hi); end
    total++; if (strobes !== 1) begin bad++; $display("FAIL word_strobes: got %0d want 1", strobes); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL word_error: got %b want 0", error); end
    total++; if (addr_log[0] !== 9'h010) begin bad++; $display("FAIL word_addr: got %h want 010", addr_log[0]); end
    total++; if ({ramRW, ramDataSize} !== 3'b110) begin bad++; $display("FAIL word_rw_size: got %b want 110", {ramRW, ramDataSize}); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL word_ready_at_done: got %b want 0", ready); end
    cycle();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL word_ready_after: got %b want 1", ready); end
  endtask

  task automatic test_halfword_wrap();
    logic [8:0] exp_addr [3];
    exp_addr[0] = 9'h1FE; exp_addr[1] = 9'h000; exp_addr[2] = 9'h002;
    auto_mfc = 1'b1; mfc_delay = 0; clear_obs();
    start(1'b0, 9'h1FE, 2'b01, 3'd3);
    run_to_done("half", 60);
    total++; if (strobes !== 3) begin bad++; $display("FAIL half_strobes: got %0d want 3", strobes); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (addr_log[i] !== exp_addr[i] || idx_log[i] !== 3'(i)) begin
        bad++;
        $display("FAIL half_beat%0d: got addr %h idx %0d want addr %h idx %0d", i, addr_log[i], idx_log[i], exp_addr[i], i);
      end
    end
    total++; if ({error, ramRW} !== 2'b00) begin bad++; $display("FAIL half_err_rw: got %b want 00", {error, ramRW}); end
    total++; if (mfa_hi !== 3) begin bad++; $display("FAIL half_mfa_cycles: got %0d want 3", mfa_hi); end
    cycle();
  endtask

  task automatic test_zero_beats();
    auto_mfc = 1'b1; mfc_delay = 1; clear_obs();
    start(1'b0, 9'h1FF, 2'b00, 3'd0);
    run_to_done("zero", 30);
    total++; if (strobes !== 1 || addr_log[0] !== 9'h1FF) begin
      bad++; $display("FAIL zero_beats: got %0d strobes addr %h want 1 strobe addr 1ff", strobes, addr_log[0]);
    end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL zero_error: got %b want 0", error); end
    cycle();
  endtask

  task automatic test_illegal();
    logic [8:0] a_tab [3];
    logic [1:0] s_tab [3];
    a_tab[0] = 9'h006; s_tab[0] = 2'b10;
    a_tab[1] = 9'h000; s_tab[1] = 2'b11;
    a_tab[2] = 9'h003; s_tab[2] = 2'b01;
    auto_mfc = 1'b1; mfc_delay = 0;
    for (int i = 0; i < 3; i++) begin
      clear_obs();
      start(1'b1, a_tab[i], s_tab[i], 3'd2);
      total++; if ({ramMFA, done, ready} !== 3'b000) begin
        bad++; $display("FAIL illegal%0d_fin: got mfa/done/ready %b want 000", i, {ramMFA, done, ready});
      end
      cycle();
      total++; if ({done, error, ready} !== 3'b110) begin
        bad++; $display("FAIL illegal%0d_done: got done/error/ready %b want 110", i, {done, error, ready});
      end
      cycle();
      total++; if ({ready, done, error, ramMFA} !== 4'b1000 || mfa_hi !== 0) begin
        bad++; $display("FAIL illegal%0d_after: got ready/done/error/mfa %b mfa_hi %0d want 1000 0", i, {ready, done, error, ramMFA}, mfa_hi);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    auto_mfc = 1'b1; mfc_delay = 3; clear_obs();
    start(1'b1, 9'h040, 2'b10, 3'd4);
    for (int i = 0; i < 60 && !(ramMFA && beat_idx == 3'd1); i++) cycle();
    total++; if (!(ramMFA && beat_idx == 3'd1)) begin
      bad++; $display("FAIL rst_mid_reach: got mfa %b idx %0d want 1 1", ramMFA, beat_idx);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    total++; if ({ramMFA, ready, done, error} !== 4'b0100) begin
      bad++; $display("FAIL rst_mid_outputs: got mfa/ready/done/error %b want 0100", {ramMFA, ready, done, error});
    end
    total++; if (beat_idx !== 3'd0 || ramAddress !== 9'h000) begin
      bad++; $display("FAIL rst_mid_state: got idx %0d addr %h want 0 000", beat_idx, ramAddress);
    end
    for (int i = 0; i < 5; i++) cycle();
    total++; if (dones !== 0 || ramMFA !== 1'b0) begin
      bad++; $display("FAIL rst_mid_no_done: got dones %0d mfa %b want 0 0", dones, ramMFA);
    end
  endtask

  task automatic test_timeout();
    auto_mfc = 1'b0; ramMFC = 1'b0; clear_obs();
    start(1'b1, 9'h080, 2'b10, 3'd3);
    for (int i = 0; i < 40 && ramMFA; i++) cycle();
`ifdef MFC_TIMEOUT_EN
    total++; if (mfa_hi !== 15 || ramMFA !== 1'b0) begin
      bad++; $display("FAIL tmo_mfa_drop: got mfa_hi %0d mfa %b want 15 0", mfa_hi, ramMFA);
    end
    run_to_done("tmo", 10);
    total++; if (error !== 1'b1 || strobes !== 0) begin
      bad++; $display("FAIL tmo_error: got error %b strobes %0d want 1 0", error, strobes);
    end
`else
    total++; if (ramMFA !== 1'b1 || dones !== 0) begin
      bad++; $display("FAIL tmo_mfa_hold: got mfa %b dones %0d want 1 0", ramMFA, dones);
    end
    auto_mfc = 1'b1; mfc_delay = 0;
    run_to_done("tmo", 40);
    total++; if (error !== 1'b0 || strobes !== 3) begin
      bad++; $display("FAIL tmo_complete: got error %b strobes %0d want 0 3", error, strobes);
    end
`endif
    cycle();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL tmo_ready: got %b want 1", ready); end
  endtask

  task automatic test_stuck_mfc();
    auto_mfc = 1'b0; ramMFC = 1'b1; clear_obs();
    start(1'b1, 9'h020, 2'b00, 3'd1);
    total++; if (ramMFA !== 1'b1) begin bad++; $display("FAIL stuck_mfa: got %b want 1", ramMFA); end
    req = 1'b1; req_addr = 9'h100; req_size = 2'b10; req_rw = 1'b0;
    cycle();
    req = 1'b0;
    total++; if ({beat_strobe, ramMFA} !== 2'b10) begin
      bad++; $display("FAIL stuck_first_assert: got strobe/mfa %b want 10", {beat_strobe, ramMFA});
    end
    cycle();
    cycle();
    total++; if (dones !== 0 || ramMFA !== 1'b0) begin
      bad++; $display("FAIL stuck_hold_release: got dones %0d mfa %b want 0 0", dones, ramMFA);
    end
    ramMFC = 1'b0;
    run_to_done("stuck", 5);
    total++; if ({error, ramRW, ramDataSize} !== 4'b0100 || ramAddress !== 9'h020 || strobes !== 1) begin
      bad++; $display("FAIL stuck_ignored_req: got err/rw/size %b addr %h strobes %0d want 0100 020 1", {error, ramRW, ramDataSize}, ramAddress, strobes);
    end
    cycle();
    cycle();
    total++; if (ready !== 1'b1 || ramMFA !== 1'b0) begin
      bad++; $display("FAIL stuck_idle: got ready %b mfa %b want 1 0", ready, ramMFA);
    end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_halfword_wrap();
    test_zero_beats();
    test_illegal();
    test_reset_mid_burst();
    test_timeout();
    test_stuck_mfc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
